aes_block_scheduler: RTL
========================

// Module: aes_block_scheduler
// PURPOSE
//  Sequences the aes_control core between the USB byte streams.
//  - Packs received bytes into 128-bit blocks and launches each block with a one-cycle ready pulse.
//  - Waits for complete, captures the result, then streams it out byte-serially with a valid/ready handshake.
//  - Watchdog drops a block if the core never completes.
// PARAMETERS
//  BLOCK_BYTES     16   bytes per AES block (fixed by core width; 128 = 8*BLOCK_BYTES)
//  TIMEOUT_CYCLES  64   max cycles in WAIT before the block is dropped and error set
// PORTS
//  clk           in   1      system clock, all logic on rising edge
//  n_rst         in   1      reset, synchronous, active-low
//  rx_valid      in   1      input byte present
//  rx_byte       in   8      input byte
//  rx_ready      out  1      scheduler accepts rx_byte this cycle
//  flush         in   1      launch partial block, zero-padded
//  aes_ready     out  1      one-cycle launch pulse to aes_control.ready
//  aes_data      out  [0:127] block to aes_control.data_in; first rx byte in [0:7]
//  aes_complete  in   1      aes_control.complete
//  aes_result    in   [0:127] aes_control.data_out
//  tx_valid      out  1      output byte present
//  tx_byte       out  8      output byte
//  tx_ready      in   1      downstream accepts tx_byte
//  busy          out  1      state != FILL
//  error         out  1      sticky watchdog flag, cleared only by reset
// BEHAVIOUR
//  Reset (n_rst=0 at clk edge): state FILL, byte index 0, watchdog timer 0.
//   All buffers 0. All outputs 0 except rx_ready, which is 1 from the first cycle after reset.
//   Reset overrides every state; a late aes_complete after reset is ignored.
//  FILL:
//   - rx_ready=1; byte accepted when rx_valid&rx_ready, stored at aes_data[8*idx +: 8] in [0:127] order; idx++.
//   - Accepting byte BLOCK_BYTES-1 -> START.
//   - flush with idx>0 -> START with unfilled bytes 0x00; flush with idx==0 ignored.
//   - flush and a byte accept in the same cycle: byte stored first, then launch.
//  START: exactly one cycle; aes_ready=1, rx_ready=0 -> WAIT.
//   aes_data held stable from START until capture.
//  WAIT:
//   - aes_complete is sampled only here, not in the START cycle.
//   - aes_complete=1 -> capture aes_result into the output register, clear the input buffer, idx=0, timer=0 -> DRAIN.
//   - Timer increments each WAIT cycle. Reaching TIMEOUT_CYCLES without complete -> error=1, clear input buffer, idx=0 -> FILL; no tx output.
//  DRAIN:
//   - tx_valid=1, tx_byte = out[8*idx +: 8].
//   - Advance idx on tx_ready; tx_byte held stable while tx_valid & !tx_ready.
//   - Accepting byte BLOCK_BYTES-1 -> FILL, idx=0, tx_valid=0 next cycle.
//   - Always BLOCK_BYTES output bytes, even for flushed partial blocks.
//  Latency: last byte accepted at edge N -> aes_ready=1 in cycle N..N+1.
//   complete sampled at edge M -> tx_valid=1 after M.
//  rx_ready=0 in START/WAIT/DRAIN: no overlap of fill and drain (single buffer pair).
//  Registered outputs only; no combinational path from rx_valid/tx_ready to any output other than none.
// STRUCTURE
//  Package aes_sched_pkg:
//   - typedef enum logic [1:0] {FILL, START, WAIT, DRAIN} sched_state_t.
//   - localparams BLOCK_BYTES, BYTE_W=8, BLOCK_W=128.
//  Sub-module flex_counter (parametrised rollover counter): one instance each for the byte index and the watchdog.
//  Everything else inline: next-state logic and 128-bit input/output registers.
// TESTING
//  1 Reset: n_rst=0 two cycles -> all outputs 0; next cycle rx_ready=1, busy=0, error=0.
//  2 Full block:
//    - Stimulus: rx 32 43 f6 a8 88 5a 30 8d 31 31 98 a2 e0 37 07 34.
//      -> aes_data=128'h3243f6a8885a308d313198a2e0370734, single aes_ready pulse.
//    - Model core: complete after 10 cycles, aes_result=128'h3925841d02dc09fbdc118597196a0b32.
//      -> tx bytes 39 25 84 1d ... 0b 32 in order, then FILL.
//  3 Flush: rx 61 62 63 then flush=1 -> aes_data=128'h616263 followed by 13 zero bytes; 16 tx bytes follow.
//  4 Backpressure: tx_ready=0 for 5 cycles at byte 7 -> tx_byte stable, no skip/duplicate; rx_ready=0 throughout DRAIN.
//  5 Watchdog: no aes_complete for TIMEOUT_CYCLES -> error=1, state FILL, rx_ready=1, tx_valid never asserted; error stays 1 through next good block.
//  6 Reset in WAIT: n_rst=0 one cycle, then aes_complete pulse -> ignored, tx_valid=0, error=0, rx_ready=1.

Source files
------------

// File: rtl/aes_sched_pkg.sv
// Shared types, sizes and byte-lane helpers for the AES block scheduler.
// Byte 0 of a block sits in the most significant lane, which is the core's [0:7].
package aes_sched_pkg;

  localparam int unsigned BLOCK_BYTES = 16;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned BLOCK_W     = BYTE_W * BLOCK_BYTES;
  localparam int unsigned IDX_W       = $clog2(BLOCK_BYTES);

  typedef enum logic [1:0] {FILL, START, WAIT, DRAIN} sched_state_t;

  // {~idx, 3'b000} is the lsb of lane idx when lane 0 is the top byte.
  function automatic logic [BYTE_W-1:0] get_byte(input logic [BLOCK_W-1:0] blk,
                                                 input logic [IDX_W-1:0]   idx);
    return blk[{~idx, 3'b000} +: BYTE_W];
  endfunction

  function automatic logic [BLOCK_W-1:0] put_byte(input logic [BLOCK_W-1:0] blk,
                                                  input logic [IDX_W-1:0]   idx,
                                                  input logic [BYTE_W-1:0]  b);
    logic [BLOCK_W-1:0] r;
    r = blk;
    r[{~idx, 3'b000} +: BYTE_W] = b;
    return r;
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Rollover counter: counts 0..rollover_val_i then wraps to 0; clear wins over enable.
// rollover_flag_o is high while the count sits at rollover_val_i.
module flex_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             count_enable_i,
  input  logic [Width-1:0] rollover_val_i,
  output logic [Width-1:0] count_o,
  output logic             rollover_flag_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (count_enable_i) begin
      count_d = (count_q == rollover_val_i) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o         = count_q;
  assign rollover_flag_o = (count_q == rollover_val_i);

endmodule

// File: rtl/aes_block_scheduler.sv
// Packs rx bytes into a block, launches it on the AES core, waits for the
// result under a watchdog, then streams the result out byte-serially.
module aes_block_scheduler
  import aes_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               rx_valid,
  input  logic [BYTE_W-1:0]  rx_byte,
  output logic               rx_ready,
  input  logic               flush,
  output logic               aes_ready,
  output logic [BLOCK_W-1:0] aes_data,
  input  logic               aes_complete,
  input  logic [BLOCK_W-1:0] aes_result,
  output logic               tx_valid,
  output logic [BYTE_W-1:0]  tx_byte,
  input  logic               tx_ready,
  output logic               busy,
  output logic               error
);

  localparam int unsigned      TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLOCK_BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  sched_state_t       state_q, state_d;
  logic [BLOCK_W-1:0] in_q, in_d;
  logic [BLOCK_W-1:0] out_q, out_d;
  logic               error_q, error_d;
  logic               rx_ready_q, rx_ready_d;
  logic               aes_ready_q, aes_ready_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d;

  logic [IDX_W-1:0] idx;
  logic             idx_last, idx_inc, idx_clear;
  logic [TMR_W-1:0] tmr_cnt;
  logic             tmr_last;
  logic             unused_tmr_cnt;

  logic rx_accept, tx_accept, launch, capture, wd_expire;

  // rx_ready_q gates acceptance so nothing is taken in the cycle leaving reset.
  assign rx_accept = (state_q == FILL) & rx_valid & rx_ready_q;
  assign launch    = (state_q == FILL) &
                     ((rx_accept & idx_last) | (flush & (rx_accept | (idx != '0))));
  assign tx_accept = (state_q == DRAIN) & tx_ready;
  assign capture   = (state_q == WAIT) & aes_complete;
  assign wd_expire = (state_q == WAIT) & ~aes_complete & tmr_last;

  assign idx_inc   = rx_accept | tx_accept;
  assign idx_clear = launch | (state_q == START) | (state_q == WAIT);

  flex_counter #(
    .Width (IDX_W)
  ) u_idx_cnt (
    .clk_i           (clk),
    .rst_ni          (n_rst),
    .clear_i         (idx_clear),
    .count_enable_i  (idx_inc),
    .rollover_val_i  (IDX_LAST),
    .count_o         (idx),
    .rollover_flag_o (idx_last)
  );

  flex_counter #(
    .Width (TMR_W)
  ) u_wdog_cnt (
    .clk_i           (clk),
    .rst_ni          (n_rst),
    .clear_i         (state_q != WAIT),
    .count_enable_i  (state_q == WAIT),
    .rollover_val_i  (TMR_LAST),
    .count_o         (tmr_cnt),
    .rollover_flag_o (tmr_last)
  );

  assign unused_tmr_cnt = ^tmr_cnt;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (launch) state_d = START;
      START:   state_d = WAIT;
      WAIT: begin
        if (capture) begin
          state_d = DRAIN;
        end else if (wd_expire) begin
          state_d = FILL;
        end
      end
      DRAIN:   if (tx_accept && idx_last) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    rx_ready_d  = (state_d == FILL);
    aes_ready_d = (state_d == START);
    tx_valid_d  = (state_d == DRAIN);
    busy_d      = (state_d != FILL);
  end

  always_comb begin
    in_d    = in_q;
    out_d   = out_q;
    error_d = error_q;
    if (rx_accept) in_d = put_byte(in_q, idx, rx_byte);
    if (capture) begin
      out_d = aes_result;
      in_d  = '0;
    end
    if (wd_expire) begin
      in_d    = '0;
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      in_q        <= '0;
      out_q       <= '0;
      error_q     <= 1'b0;
      rx_ready_q  <= 1'b0;
      aes_ready_q <= 1'b0;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      in_q        <= in_d;
      out_q       <= out_d;
      error_q     <= error_d;
      rx_ready_q  <= rx_ready_d;
      aes_ready_q <= aes_ready_d;
      tx_valid_q  <= tx_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign aes_ready = aes_ready_q;
  assign aes_data  = in_q;
  assign tx_valid  = tx_valid_q;
  assign tx_byte   = tx_valid_q ? get_byte(out_q, idx) : '0;
  assign busy      = busy_q;
  assign error     = error_q;

endmodule
